// File: rtl/aes_pkg.sv
// Shared AES constants: key width, round limit, round constants and the FIPS-197 S-box.
// Both the key schedule and the SubBytes stage use this S-box table.
package aes_pkg;

    localparam int AES_KEY_W      = 128;
    localparam int AES_MAX_ROUNDS = 10;

    // Indexed directly by round number 1..10; the spare entries are zero.
    localparam logic [7:0] AES_RCON [0:15] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    localparam logic [7:0] AES_SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return AES_SBOX[b];
    endfunction

endpackage

// File: rtl/aes_sbox_byte.sv
// Single-byte combinational AES S-box lookup.
module aes_sbox_byte
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    assign out_byte = sbox(in_byte);

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128 key schedule: emits round keys 0..NUM_ROUNDS over a valid/ready stream,
// computing each key from the previous one in a single cycle.
//
// state   | meaning
// IDLE    | waiting for start; outputs hold last key/index, rk_valid low
// EMIT    | round_key/round_idx valid, advance on each rk_ready beat
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_MAX_ROUNDS,
    parameter int KEY_W      = AES_KEY_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [0:KEY_W-1] key_in,
    input  logic             rk_ready,
    output logic             rk_valid,
    output logic [0:KEY_W-1] round_key,
    output logic [3:0]       round_idx,
    output logic             busy,
    output logic             done
);

    if (KEY_W != AES_KEY_W) begin : g_bad_key_w
        $error("aes_key_expander: KEY_W must be 128");
    end
    if (NUM_ROUNDS < 1 || NUM_ROUNDS > AES_MAX_ROUNDS) begin : g_bad_rounds
        $error("aes_key_expander: NUM_ROUNDS must be 1..10");
    end

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_EMIT  = 1'b1;
    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    logic [0:0]       state_q, state_d;
    logic [0:KEY_W-1] key_q, key_d;
    logic [3:0]       idx_q, idx_d;
    logic             done_q, done_d;

    logic [3:0]       idx_inc;
    logic [7:0]       rcon;
    logic [31:0]      w0, w1, w2, w3;
    logic [31:0]      rot_w, sub_w, t_w;
    logic [31:0]      n0, n1, n2, n3;
    logic [0:KEY_W-1] next_key;

    assign idx_inc = idx_q + 4'd1;
    assign rcon    = AES_RCON[idx_inc];

    assign w0 = key_q[0:31];
    assign w1 = key_q[32:63];
    assign w2 = key_q[64:95];
    assign w3 = key_q[96:127];

    assign rot_w = {w3[23:0], w3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox_byte u_sbox (
            .in_byte  (rot_w[8*g +: 8]),
            .out_byte (sub_w[8*g +: 8])
        );
    end

    assign t_w = sub_w ^ {rcon, 24'h0};
    assign n0  = w0 ^ t_w;
    assign n1  = w1 ^ n0;
    assign n2  = w2 ^ n1;
    assign n3  = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_EMIT;
                    key_d   = key_in;
                    idx_d   = 4'd0;
                end
            end
            ST_EMIT: begin
                if (rk_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        key_d = next_key;
                        idx_d = idx_inc;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            idx_q   <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // Valid and busy coincide: both span accepted start to last accepted beat.
    assign rk_valid  = (state_q == ST_EMIT);
    assign busy      = (state_q == ST_EMIT);
    assign round_key = key_q;
    assign round_idx = idx_q;
    assign done      = done_q;

endmodule
